// File: rtl/mac_pkg.sv
// Shared widths and FSM encoding for the MAC operand feeder.
package mac_pkg;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/mac_feed_fifo.sv
// Operand-pair FIFO: power-of-2 depth, registered storage, no read bypass.
module mac_feed_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  // flush wins over a same-cycle push or pop
  assign do_push = push && !full && !flush && !rst;
  assign do_pop  = pop && !empty && !flush;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/mac_feeder.sv
// Streams VEC_LEN operand pairs from a FIFO into a MAC, then flags the finished dot product.
module mac_feeder #(
  parameter int DATA_W  = mac_pkg::DATA_W,
  parameter int DEPTH   = 8,
  parameter int VEC_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic              mac_clr,
  output logic              dot_done,
  output logic [7:0]        vec_cnt
);

  import mac_pkg::*;

  localparam int CW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;

  state_t              state, state_nxt;
  logic [CW-1:0]       pair_cnt, pair_nxt;
  logic [DATA_W-1:0]   a_nxt, b_nxt;
  logic [7:0]          vec_nxt;
  logic [2*DATA_W-1:0] fifo_dout;
  logic                push, pop, full, empty;

  assign in_ready = !rst && !full;
  assign push     = in_valid && in_ready;

  mac_feed_fifo #(
    .W     (2*DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .din   ({in_a, in_b}),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_nxt = state;
    pair_nxt  = pair_cnt;
    a_nxt     = a;
    b_nxt     = b;
    vec_nxt   = vec_cnt;
    pop       = 1'b0;
    mac_clr   = (state == IDLE) || (state == DONE);
    dot_done  = (state == DONE);

    case (state)
      IDLE: begin
        a_nxt = '0;
        b_nxt = '0;
        if (!empty) state_nxt = STREAM;
      end
      STREAM: begin
        if (!empty) begin
          pop   = 1'b1;
          a_nxt = fifo_dout[2*DATA_W-1:DATA_W];
          b_nxt = fifo_dout[DATA_W-1:0];
          if (pair_cnt == CW'(VEC_LEN - 1)) begin
            pair_nxt  = '0;
            state_nxt = DRAIN;
          end else begin
            pair_nxt = pair_cnt + CW'(1);
          end
        end else begin
          a_nxt = '0;
          b_nxt = '0;
        end
      end
      DRAIN: begin
        a_nxt     = '0;
        b_nxt     = '0;
        state_nxt = DONE;
      end
      default: begin
        vec_nxt   = vec_cnt + 8'd1;
        state_nxt = IDLE;
      end
    endcase

    // abort overrides everything above, including the DONE count
    if (flush) begin
      state_nxt = IDLE;
      pair_nxt  = '0;
      a_nxt     = '0;
      b_nxt     = '0;
      vec_nxt   = vec_cnt;
      pop       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pair_cnt <= '0;
      a        <= '0;
      b        <= '0;
      vec_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      pair_cnt <= pair_nxt;
      a        <= a_nxt;
      b        <= b_nxt;
      vec_cnt  <= vec_nxt;
    end
  end

endmodule

// File: tb/tb_mac_feeder.sv
// Bench for mac_feeder: queue-based reference model, attached MAC, directed scenarios.
module tb_mac_feeder;

  localparam int DATA_W  = 8;
  localparam int DEPTH   = 8;
  localparam int VEC_LEN = 4;

  localparam int M_IDLE   = 0;
  localparam int M_STREAM = 1;
  localparam int M_DRAIN  = 2;
  localparam int M_DONE   = 3;

  logic              clk = 1'b0;
  logic              rst, flush, in_valid;
  logic [DATA_W-1:0] in_a, in_b, a, b;
  logic              in_ready, mac_clr, dot_done;
  logic [7:0]        vec_cnt;
  logic [15:0]       mac_out;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;
  bit saw_full = 1'b0;
  int dut_done_cnt = 0;
  logic [15:0] last_mac;

  mac_feeder #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .VEC_LEN (VEC_LEN)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .a        (a),
    .b        (b),
    .mac_clr  (mac_clr),
    .dot_done (dot_done),
    .vec_cnt  (vec_cnt)
  );

  always #5 clk = ~clk;

  // the MAC the feeder drives
  always @(posedge clk) begin
    if (mac_clr) mac_out <= '0;
    else         mac_out <= mac_out + 16'(a) * 16'(b);
  end

  // reference model: queue of accepted pairs plus a vector phase
  logic [15:0] q[$];
  int          m_mode  = M_IDLE;
  int          m_taken = 0;
  int          m_sum   = 0;
  logic [7:0]  m_vec   = '0;
  logic [7:0]  ea = '0, eb = '0;

  always @(posedge clk) begin : model_step
    logic        acc;
    logic [15:0] p;
    acc = in_valid && !rst && (q.size() < DEPTH);
    if (rst) begin
      q.delete(); m_mode = M_IDLE; m_taken = 0; m_sum = 0; m_vec = '0; ea = '0; eb = '0;
    end else if (flush) begin
      q.delete(); m_mode = M_IDLE; m_taken = 0; m_sum = 0; ea = '0; eb = '0;
    end else begin
      case (m_mode)
        M_IDLE: begin
          ea = '0; eb = '0;
          if (q.size() != 0) m_mode = M_STREAM;
        end
        M_STREAM: begin
          if (q.size() != 0) begin
            p = q.pop_front();
            ea = p[15:8]; eb = p[7:0];
            m_sum += int'(ea) * int'(eb);
            m_taken++;
            if (m_taken == VEC_LEN) begin
              m_taken = 0;
              m_mode  = M_DRAIN;
            end
          end else begin
            ea = '0; eb = '0;
          end
        end
        M_DRAIN: begin
          ea = '0; eb = '0; m_mode = M_DONE;
        end
        default: begin
          m_vec++; m_sum = 0; m_mode = M_IDLE;
        end
      endcase
      if (acc) q.push_back({in_a, in_b});
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", in_ready, !rst && (q.size() < DEPTH));
      check("a", a, ea);
      check("b", b, eb);
      check("dot_done", dot_done, m_mode == M_DONE);
      check("mac_clr", mac_clr, (m_mode == M_IDLE) || (m_mode == M_DONE));
      check("vec_cnt", vec_cnt, m_vec);
      if (m_mode == M_DONE) check("mac_sum", mac_out, 16'(m_sum));
      if (!rst && !in_ready) saw_full = 1'b1;
      if (dot_done) begin
        dut_done_cnt++;
        last_mac = mac_out;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_pair(input logic [7:0] x, input logic [7:0] y);
    in_a = x; in_b = y; in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (in_ready) begin
        tick();
        in_valid = 1'b0;
        return;
      end
      tick();
    end
    in_valid = 1'b0;
    check("push_timeout", 0, 1);
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 3000; i++) begin
      if (dut_done_cnt >= target) return;
      tick();
    end
    check("done_timeout", dut_done_cnt, target);
  endtask

  logic [7:0] ta[4] = '{8'd5, 8'd3, 8'd7, 8'd8};
  logic [7:0] tb4[4] = '{8'd2, 8'd4, 8'd9, 8'd6};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got still running, want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
    @(posedge clk); #2;
    chk_en = 1'b1;
    tick();
    @(negedge clk);
    check("rst_a", a, 0);
    check("rst_b", b, 0);
    check("rst_dot_done", dot_done, 0);
    check("rst_mac_clr", mac_clr, 1);
    check("rst_in_ready", in_ready, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rel_mac_clr", mac_clr, 1);
    check("rel_a", a, 0);
    check("rel_in_ready", in_ready, 1);
    tick();

    // back-to-back vector
    base = dut_done_cnt;
    for (int i = 0; i < 4; i++) push_pair(ta[i], tb4[i]);
    wait_done(base + 1);
    check("s1_sum", last_mac, 133);
    check("s1_vec", vec_cnt, 1);
    repeat (6) tick();
    check("s1_once", dut_done_cnt, base + 1);

    // three bubbles after pair 2
    base = dut_done_cnt;
    push_pair(ta[0], tb4[0]);
    push_pair(ta[1], tb4[1]);
    repeat (3) tick();
    push_pair(ta[2], tb4[2]);
    push_pair(ta[3], tb4[3]);
    wait_done(base + 1);
    check("s2_sum", last_mac, 133);
    check("s2_vec", vec_cnt, 2);
    repeat (4) tick();

    // continuous stream until the FIFO fills
    base = dut_done_cnt;
    saw_full = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (i < 4) push_pair(ta[i], tb4[i]);
      else       push_pair(8'(i * 7), 8'(i + 3));
      if (i == 4) begin
        wait_done(base + 1);
        check("s3_first_sum", last_mac, 133);
      end
    end
    wait_done(base + 8);
    check("s3_saw_full", saw_full, 1);
    check("s3_vec", vec_cnt, 10);
    repeat (4) tick();
    check("s3_count", dut_done_cnt, base + 8);

    // flush mid-vector, then (1,1) x4
    base = dut_done_cnt;
    push_pair(8'd5, 8'd2);
    push_pair(8'd3, 8'd4);
    repeat (4) tick();
    flush = 1'b1; in_valid = 1'b1; in_a = 8'd9; in_b = 8'd9;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    tick();
    check("s4_no_done", dut_done_cnt, base);
    for (int i = 0; i < 4; i++) push_pair(8'd1, 8'd1);
    wait_done(base + 1);
    check("s4_sum", last_mac, 4);
    check("s4_vec", vec_cnt, 11);
    repeat (4) tick();

    // reset during DRAIN
    base = dut_done_cnt;
    for (int i = 0; i < 4; i++) push_pair(ta[i], tb4[i]);
    for (int i = 0; i < 50 && m_mode != M_DRAIN; i++) tick();
    check("s5_reached_drain", m_mode, M_DRAIN);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("s5_vec", vec_cnt, 0);
    check("s5_mac_clr", mac_clr, 1);
    check("s5_in_ready", in_ready, 1);
    check("s5_dot_done", dot_done, 0);
    repeat (10) tick();
    check("s5_no_done", dut_done_cnt, base);

    // 256 zero vectors wrap vec_cnt
    base = dut_done_cnt;
    for (int i = 0; i < 256 * VEC_LEN; i++) push_pair(8'd0, 8'd0);
    wait_done(base + 256);
    repeat (6) tick();
    check("s6_count", dut_done_cnt, base + 256);
    check("s6_vec_wrap", vec_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
